// File: rtl/pipeline_trace_buffer.sv
// Circular trace buffer for pipeline probe words: captures every valid sample while armed,
// freezes after a masked-compare trigger plus a post-trigger count, then reads back oldest-first.
module pipeline_trace_buffer #(
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 5,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sample_valid,
   input  logic [CHANNELS*DATA_W-1:0]   probe_bus,
   input  logic                         arm,
   input  logic                         abort,
   input  logic [7:0]                   trig_ch,
   input  logic [DATA_W-1:0]            trig_value,
   input  logic [DATA_W-1:0]            trig_mask,
   input  logic [ADDR_W-1:0]            post_len,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [CHANNELS*DATA_W-1:0]   rd_data,
   output logic [ADDR_W-1:0]            rd_index,
   output logic [1:0]                   state,
   output logic                         triggered,
   output logic [ADDR_W:0]              count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(DEPTH);
   localparam logic [7:0]      CH_LIM = 8'(CHANNELS);

   logic [CHANNELS*DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              trig_q, trig_d;
   logic [ADDR_W-1:0] post_q, post_d;
   logic [ADDR_W:0]   rd_idx_q, rd_idx_d;

   logic [DATA_W-1:0] chan_sel;
   logic              trig_hit;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_start;
   logic [ADDR_W-1:0] rd_addr;

   always_comb begin
      chan_sel = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (trig_ch == 8'(k)) chan_sel = probe_bus[k*DATA_W +: DATA_W];
      end
      trig_hit = (trig_ch < CH_LIM) && (((chan_sel ^ trig_value) & trig_mask) == '0);
   end

   assign wr_en = !abort && sample_valid && (state_q == ARMED || state_q == POST);

   // Once the buffer has wrapped, the slot about to be overwritten holds the oldest sample.
   assign rd_start = (count_q == FULL) ? wr_ptr_q : '0;
   assign rd_addr  = rd_start + rd_idx_q[ADDR_W-1:0];
   assign rd_valid = (state_q == DONE) && (rd_idx_q < count_q);
   assign rd_data  = rd_valid ? mem_q[rd_addr] : '0;
   assign rd_index = rd_idx_q[ADDR_W-1:0];

   assign state     = state_q;
   assign triggered = trig_q;
   assign count     = count_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      trig_d   = trig_q;
      post_d   = post_q;
      rd_idx_d = rd_idx_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         count_d  = (count_q == FULL) ? count_q : count_q + 1'b1;
      end
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (arm) begin
                  state_d  = ARMED;
                  wr_ptr_d = '0;
                  count_d  = '0;
                  trig_d   = 1'b0;
                  rd_idx_d = '0;
               end else if (rd_valid && rd_ready) begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
            ARMED: begin
               if (sample_valid && trig_hit) begin
                  trig_d  = 1'b1;
                  post_d  = post_len;
                  state_d = (post_len == '0) ? DONE : POST;
               end
            end
            POST: begin
               if (sample_valid) begin
                  post_d = post_q - 1'b1;
                  if (post_q == ADDR_W'(1)) state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         trig_q   <= 1'b0;
         post_q   <= '0;
         rd_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         trig_q   <= trig_d;
         post_q   <= post_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   // Buffer storage is deliberately left out of reset so a frozen trace survives a reset for debug.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= probe_bus;
   end

endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
- Parametrised, synthesisable successor to the per-cycle pipeline console monitor.
- Captures CHANNELS probe words (e.g. PC, instruction, ALU result, mem data, WB data) each valid cycle into a circular buffer of DEPTH entries.
- A masked-compare trigger on a selectable channel freezes the buffer after a programmable post-trigger count.
- Captured samples are read back oldest-first over a valid/ready handshake.

Parameters:
- DATA_W, 32, width of one probe channel
- CHANNELS, 5, number of probe channels captured per sample
- DEPTH, 16, buffer entries; power of two, minimum 4
- ADDR_W, 4, log2(DEPTH); must match DEPTH

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset (0 = reset)
- sample_valid  input  1  probe bus holds a sample this cycle
- probe_bus  input  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- arm  input  1  one-cycle pulse; starts a capture
- abort  input  1  one-cycle pulse; return to IDLE
- trig_ch  input  8  channel index compared for trigger; values >= CHANNELS never match
- trig_value  input  DATA_W  trigger compare value
- trig_mask  input  DATA_W  1 = bit participates in compare
- post_len  input  ADDR_W  samples stored after the trigger sample
- rd_valid  output  1  rd_data holds an unread entry
- rd_ready  input  1  consumer accepts rd_data
- rd_data  output  CHANNELS*DATA_W  entry being read
- rd_index  output  ADDR_W  age of rd_data; 0 = oldest
- state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- triggered  output  1  trigger seen in the current capture
- count  output  ADDR_W+1  valid entries stored; saturates at DEPTH

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wr_ptr=0, count=0, triggered=0, rd_valid=0, rd_index=0, post counter=0.
  - rd_data reads 0 after reset.
  - Buffer contents are not cleared.
- IDLE: no writes.
  - arm -> ARMED on the next edge; clears wr_ptr, count, triggered.
- ARMED: each edge with sample_valid=1:
  - Write probe_bus to entry wr_ptr.
  - wr_ptr increments and wraps DEPTH-1 -> 0.
  - count increments, saturating at DEPTH; saturation means oldest data was overwritten.
  - Trigger condition: sample_valid=1 and ((channel[trig_ch] ^ trig_value) & trig_mask) == 0.
  - The trigger sample is itself written and counts as a pre-trigger entry.
  - On trigger: triggered=1, post counter loaded with post_len; next state is POST, or DONE if post_len=0.
  - sample_valid=0: no write and no trigger evaluation.
- POST: each valid sample is written as in ARMED and the post counter decrements.
  - The write that takes the counter 1 -> 0 moves state to DONE on the same edge.
  - Trigger condition is ignored in POST.
- DONE: no writes; buffer frozen.
  - Read start pointer is wr_ptr if count==DEPTH, otherwise 0.
  - rd_valid=1 while rd_index < count.
  - rd_data is combinational from entry (start + rd_index) mod DEPTH.
  - Transfer occurs when rd_valid & rd_ready; rd_index then increments.
  - After the last transfer rd_valid=0 and state stays DONE.
  - rd_valid is 0 in every other state. rd_ready without rd_valid has no effect.
  - arm in DONE re-arms: rd_index=0, then as from IDLE.
- Simultaneous events and rule details:
  - abort overrides arm and returns to IDLE from any state; triggered and count are held for inspection.
  - arm while ARMED or POST is ignored.
  - count=0 in DONE (trigger-free states only) gives rd_valid=0.
  - post_len >= DEPTH is impossible by width. post_len = DEPTH-1 with a full buffer leaves exactly one pre-trigger entry, the trigger sample.
  - Throughput: one write per cycle, one read per cycle; no bubbles.
- A reset assertion mid-capture or mid-readout takes effect immediately; a new arm is required afterwards.

Test Plan:
- DEPTH=8, trig_ch=0, mask=FFFFFFFF, value=0x20, post_len=2; PC channel 0x00,0x04,... valid every cycle -> DONE after PC 0x28 is written. Readout oldest-first: 0x0C,0x10,0x14,0x18,0x1C,0x20,0x24,0x28 with rd_index 0..7. count=8.
- Same setup with trigger on the third sample (0x08) and post_len=0 -> DONE next edge, count=3, readout 0x00,0x04,0x08, then rd_valid=0.
- sample_valid toggled 1,0,1,0 during POST with post_len=3 -> only valid cycles are stored; DONE after the third valid post sample; no duplicate entries.
- rd_ready held 0 for 5 cycles in DONE -> rd_data and rd_index stable, rd_valid=1. Then rd_ready=1 -> one entry per cycle.
- abort and arm asserted together in POST -> state=IDLE next edge. reset=0 mid-readout -> rd_valid=0, state=IDLE immediately, without waiting for a clock edge.
- trig_mask=0xFF00, value=0x1200, channel 1 (instruction) 0x000012AB -> trigger fires. trig_ch=7 -> never triggers; buffer wraps with count=8 and state stays ARMED.
